wb_aes_driver: RTL and testbench
================================

# wb_aes_driver

Wishbone B3 classic-cycle master that drives the AES register block (key, data-in, data-out, control/status windows) through one complete operation. It sits between a host-side command interface (capture/trigger logic or test sequencer) and the AES Wishbone slave. It executes key load, data load, start, status polling and result readback autonomously. It reports completion with a one-cycle pulse and a 128-bit result.

## Interface
- BASE_ADR, 32'h0000_0000, byte base address of the AES register block
- ACK_TIMEOUT, 255, max cycles waiting for wb_ack_i per access before error
- POLL_MAX, 1023, max status reads while busy before error
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin operation when idle; ignored while busy_o=1
- skip_key_i  in  1  sampled at start; 1 = skip the 8 key writes (reuse loaded key)
- dec_i  in  1  sampled at start; 1 = decrypt
- size_i  in  2  sampled at start; 0=128, 1=192, 2=256-bit key
- key_i  in  256  sampled at start; key word x = key_i[255-32x -: 32]; 128-bit key in key_i[255:128]
- data_i  in  128  sampled at start; data word x = data_i[127-32x -: 32]
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse on success
- err_o  out  1  sticky until next accepted start
- result_o  out  128  result; word x at [127-32x -: 32]; holds until next done_o
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  always 4'hF during an access
- wb_we_o  out  1  write enable
- wb_cyc_o, wb_stb_o  out  1 each  asserted together
- wb_cti_o  out  3  constant 3'b000
- wb_bte_o  out  2  constant 2'b00
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  access acknowledge
- wb_err_i  in  1  access error

## Operation
- Register map (offsets from BASE_ADR): key words 0..7 at 0x00-0x1C; data-in words 0..3 at 0x20-0x2C; result words 0..3 at 0x30-0x3C; control/status at 0x40.
- Control write value: {23'h0, 1'b0, 4'h0, size, dec, 1'b1}; bit0 load, bit1 dec, bits3:2 size; bit8 (soft reset) always 0.
- Status read: bit16 = load|busy; nonzero means AES still working.
- States: IDLE -> KEY (words 0..7; skipped if skip_key) -> DATA (words 0..3) -> CTRL -> POLL -> READ (words 0..3) -> IDLE with done_o. Any error -> IDLE with err_o=1.
- POLL: repeat status read until bit16=0; the read returning 0 ends POLL. POLL_MAX reads with bit16=1 -> error.
- Error sources: wb_err_i sampled with stb high; ACK_TIMEOUT cycles without ack.
- Reset values: all outputs 0 except wb_sel_o=0, result_o=0, err_o=0; state IDLE.

## Timing
- Outputs registered. Access starts with cyc/stb/we/adr/dat set; held until wb_ack_i or wb_err_i sampled high.
- Cycle after ack: cyc=stb=0 for exactly one cycle (mandatory gap for the slave's toggling classic-cycle ack); next access follows.
- Read data captured on the ack cycle.
- start_i accepted in IDLE: busy_o=1 next cycle, first access issued same cycle.
- done_o pulses the cycle after the 4th result ack, with busy_o=0 and result_o valid that cycle.
- start_i during busy ignored, no queueing. start_i on done_o cycle accepted (IDLE reached).
- Ack timeout counter resets per access; simultaneous ack and timeout expiry -> ack wins.
- Async reset mid-access: cyc/stb drop immediately; no partial result reported.

## Structure
- Shared package (with wb_common.v helpers): register offsets, status busy bit index 16, control bit positions, state encoding.
- Sub-module wb_master_port: single-access engine (req/we/adr/dat in; ack/err/rdata/timeout out; gap cycle and ack timeout). wb_aes_driver holds the sequencing FSM and word counters.

## Test plan
- FIPS-197 AES-128: key_i[255:128]=000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, size 0 against the AES slave -> 8 key writes, 4 data writes, ctrl write 0x00000001, result 69c4e0d86a7b0430d8cdb78070b4c55a, done_o pulse.
- Decrypt the same key with skip_key_i=1, data 69c4...c55a, dec_i=1 -> no writes to 0x00-0x1C, ctrl 0x00000003, result 00112233445566778899aabbccddeeff.
- Bus model never acks the 3rd key write -> stb held exactly 255 cycles, then err_o=1, busy_o=0, no done_o.
- Status stuck at 0x00010000 -> exactly 1023 status reads, then err_o=1.
- wb_err_i on the 2nd data write -> err_o=1 next cycle; following start clears err_o and completes normally.
- wb_rst_n_i low during POLL -> cyc/stb 0 immediately, all outputs at reset values, busy_o=0.

Source files
------------

// File: rtl/wb_aes_driver_pkg.sv
// Shared definitions for the AES Wishbone driver.
// Holds the AES register-block offsets, control/status bit positions, the
// sequencer state encoding and small helpers for word selection, register
// addressing and control-word assembly.
package wb_aes_driver_pkg;

    localparam logic [7:0] OFS_KEY  = 8'h00;
    localparam logic [7:0] OFS_DATA = 8'h20;
    localparam logic [7:0] OFS_RES  = 8'h30;
    localparam logic [7:0] OFS_CTRL = 8'h40;

    localparam int STAT_BUSY_BIT = 16;

    localparam int CTRL_LOAD_BIT = 0;
    localparam int CTRL_DEC_BIT  = 1;
    localparam int CTRL_SIZE_LSB = 2;
    localparam int CTRL_SRST_BIT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_DATA,
        ST_CTRL,
        ST_POLL,
        ST_READ
    } state_t;

    // Key word i is the i-th 32-bit slice counting down from the MSB.
    function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] i);
        logic [255:0] s;
        s = k << {i, 5'd0};
        return s[255:224];
    endfunction

    function automatic logic [31:0] data_word(input logic [127:0] d, input logic [1:0] i);
        logic [127:0] s;
        s = d << {i, 5'd0};
        return s[127:96];
    endfunction

    function automatic logic [31:0] reg_adr(input logic [31:0] base, input logic [7:0] ofs,
                                            input logic [2:0] idx);
        return base + {24'h0, ofs} + {27'h0, idx, 2'b00};
    endfunction

    // Soft reset is never requested: a load always runs on the current key.
    function automatic logic [31:0] ctrl_word(input logic [1:0] size, input logic dec);
        logic [31:0] w;
        w = '0;
        w[CTRL_LOAD_BIT]            = 1'b1;
        w[CTRL_DEC_BIT]             = dec;
        w[CTRL_SIZE_LSB +: 2]       = size;
        w[CTRL_SRST_BIT]            = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/wb_aes_driver_if.sv
// Wishbone B3 classic-cycle bus between the AES driver (master) and the AES
// register block (slave).
//   wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o/wb_cti_o/wb_bte_o : master -> slave
//   wb_dat_i/wb_ack_i/wb_err_i                                               : slave -> master
interface wb_aes_driver_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_aes_driver_master_port.sv
// Single-access Wishbone master engine.
// Launches one classic-cycle access when idle and req is high, holds it until
// ack, bus error or ack timeout, then drops cyc/stb.
//   wb_clk_i, wb_rst_n_i : clock, async active-low reset
//   req, we, adr, dat    : access request (sampled only while no access is open)
//   ack                  : access completed normally (combinational, valid on the ack cycle)
//   err                  : access failed by wb_err_i or ack timeout
//   rdata                : read data, valid together with ack
//   wb                   : Wishbone master modport
module wb_aes_driver_master_port #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    wb_aes_driver_if.master wb
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic          cyc_q;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [TW-1:0] tmr_q;
    logic          tmr_tc;

    // Terminal count only matters when no ack arrives in that same cycle.
    assign tmr_tc = (tmr_q == '0);
    assign ack    = cyc_q && wb.wb_ack_i && !wb.wb_err_i;
    assign err    = cyc_q && (wb.wb_err_i || (!wb.wb_ack_i && tmr_tc));
    assign rdata  = wb.wb_dat_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            tmr_q <= '0;
        end else if (cyc_q) begin
            // Closing here yields the one idle cycle before any following access.
            if (ack || err) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
            end else begin
                tmr_q <= tmr_q - TW'(1);
            end
        end else if (req) begin
            cyc_q <= 1'b1;
            we_q  <= we;
            adr_q <= adr;
            dat_q <= dat;
            tmr_q <= TW'(ACK_TIMEOUT - 1);
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = {4{cyc_q}};
    assign wb.wb_cti_o = 3'b000;
    assign wb.wb_bte_o = 2'b00;

endmodule

// File: rtl/wb_aes_driver.sv
// AES register-block driver: runs one complete AES operation over Wishbone.
//   wb_clk_i, wb_rst_n_i      : clock, async active-low reset
//   start_i                   : begin an operation (only while idle)
//   skip_key_i, dec_i, size_i : operation options, captured at start
//   key_i, data_i             : key and input block, captured at start
//   busy_o                    : operation in progress
//   done_o                    : one-cycle success pulse, result_o valid
//   err_o                     : sticky failure flag, cleared by the next accepted start
//   result_o                  : last successful result
//   wb                        : Wishbone master modport
//
// state   | meaning
// IDLE    | waiting for start_i; first access launched on acceptance
// KEY     | writing key words 0..7
// DATA    | writing data-in words 0..3
// CTRL    | writing the control word (load, dec, size)
// POLL    | reading status until the busy bit clears
// READ    | reading result words 0..3
module wb_aes_driver
    import wb_aes_driver_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned POLL_MAX    = 1023
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_n_i,
    input  logic         start_i,
    input  logic         skip_key_i,
    input  logic         dec_i,
    input  logic [1:0]   size_i,
    input  logic [255:0] key_i,
    input  logic [127:0] data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [127:0] result_o,
    wb_aes_driver_if.master wb
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [PW-1:0] poll_q, poll_d;

    logic          dec_q;
    logic [1:0]    size_q;
    logic [255:0]  key_q;
    logic [127:0]  data_q;
    logic [95:0]   rd_buf_q;

    logic          req, we;
    logic [31:0]   adr, dat;
    logic          p_ack, p_err;
    logic [31:0]   p_rdata;
    logic          accept, finish, fail;

    wb_aes_driver_master_port #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_port (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .req       (req),
        .we        (we),
        .adr       (adr),
        .dat       (dat),
        .ack       (p_ack),
        .err       (p_err),
        .rdata     (p_rdata),
        .wb        (wb)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
        end
    end

    // Outside IDLE, req stays high; the port only takes it once the
    // previous access has closed, which is how the next access follows the gap.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        poll_d  = poll_q;
        req     = 1'b0;
        we      = 1'b1;
        adr     = reg_adr(BASE_ADR, OFS_KEY, idx_q);
        dat     = key_word(key_q, idx_q);
        accept  = 1'b0;
        finish  = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req = start_i;
                // Inputs are used directly so the first access goes out on acceptance.
                if (skip_key_i) begin
                    adr = reg_adr(BASE_ADR, OFS_DATA, 3'd0);
                    dat = data_word(data_i, 2'd0);
                end else begin
                    adr = reg_adr(BASE_ADR, OFS_KEY, 3'd0);
                    dat = key_word(key_i, 3'd0);
                end
                if (start_i) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = skip_key_i ? ST_DATA : ST_KEY;
                end
            end
            ST_KEY: begin
                req = 1'b1;
                if (p_ack) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                req = 1'b1;
                adr = reg_adr(BASE_ADR, OFS_DATA, {1'b0, idx_q[1:0]});
                dat = data_word(data_q, idx_q[1:0]);
                if (p_ack) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q[1:0] == 2'd3) begin
                        idx_d   = '0;
                        state_d = ST_CTRL;
                    end
                end
            end
            ST_CTRL: begin
                req = 1'b1;
                adr = reg_adr(BASE_ADR, OFS_CTRL, 3'd0);
                dat = ctrl_word(size_q, dec_q);
                if (p_ack) begin
                    poll_d  = PW'(POLL_MAX - 1);
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                req = 1'b1;
                we  = 1'b0;
                adr = reg_adr(BASE_ADR, OFS_CTRL, 3'd0);
                dat = '0;
                if (p_ack) begin
                    if (!p_rdata[STAT_BUSY_BIT]) begin
                        idx_d   = '0;
                        state_d = ST_READ;
                    end else if (poll_q == '0) begin
                        fail    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        poll_d = poll_q - PW'(1);
                    end
                end
            end
            ST_READ: begin
                req = 1'b1;
                we  = 1'b0;
                adr = reg_adr(BASE_ADR, OFS_RES, {1'b0, idx_q[1:0]});
                dat = '0;
                if (p_ack) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q[1:0] == 2'd3) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && p_err) begin
            fail    = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Result words collect in a shadow buffer so result_o only changes on success.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            result_o <= '0;
            dec_q    <= 1'b0;
            size_q   <= '0;
            key_q    <= '0;
            data_q   <= '0;
            rd_buf_q <= '0;
        end else begin
            done_o <= finish;
            if (accept) begin
                busy_o <= 1'b1;
                err_o  <= 1'b0;
                dec_q  <= dec_i;
                size_q <= size_i;
                key_q  <= key_i;
                data_q <= data_i;
            end
            if (finish) begin
                busy_o   <= 1'b0;
                result_o <= {rd_buf_q, p_rdata};
            end else if (p_ack && state_q == ST_READ) begin
                rd_buf_q <= {rd_buf_q[63:0], p_rdata};
            end
            if (fail) begin
                busy_o <= 1'b0;
                err_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_aes_driver.sv
module tb_wb_aes_driver;

    logic         wb_clk_i   = 1'b0;
    logic         wb_rst_n_i = 1'b0;
    logic         start_i    = 1'b0;
    logic         skip_key_i = 1'b0;
    logic         dec_i      = 1'b0;
    logic [1:0]   size_i     = 2'd0;
    logic [255:0] key_i      = '0;
    logic [127:0] data_i     = '0;
    logic         busy_o, done_o, err_o;
    logic [127:0] result_o;

    wb_aes_driver_if wb();

    wb_aes_driver dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .start_i   (start_i),
        .skip_key_i(skip_key_i),
        .dec_i     (dec_i),
        .size_i    (size_i),
        .key_i     (key_i),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .result_o  (result_o),
        .wb        (wb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    localparam logic [255:0] FIPS_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int total = 0;
    int bad   = 0;

    // slave behaviour knobs (written by the stimulus only)
    int          noack_n    = -1;
    logic [31:0] err_adr    = 32'hFFFF_FFFF;
    bit          stuck      = 1'b0;
    int          busy_reads = 0;
    logic [31:0] res_mem [4];
    int          clr_gen    = 0;

    // slave observations (written by the slave only)
    int          clr_seen = 0;
    int          acc_n = 0, run = 0, last_run = 0;
    int          key_wr = 0, data_wr = 0, ctrl_wr = 0, stat_rd = 0, res_rd = 0;
    bit          err_done = 1'b0;
    logic [31:0] key_words [8];
    logic [31:0] data_words [4];
    logic [31:0] ctrl_val;

    // Register-block model: acks one cycle into each access, logs writes.
    always @(negedge wb_clk_i) begin
        if (clr_seen != clr_gen) begin
            clr_seen = clr_gen;
            acc_n = 0; run = 0; last_run = 0;
            key_wr = 0; data_wr = 0; ctrl_wr = 0; stat_rd = 0; res_rd = 0;
            err_done = 1'b0;
            ctrl_val = '0;
            for (int i = 0; i < 8; i++) key_words[i] = '0;
            for (int i = 0; i < 4; i++) data_words[i] = '0;
        end
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        if (!(wb.wb_cyc_o && wb.wb_stb_o)) begin
            if (run != 0) last_run = run;
            run = 0;
        end else begin
            if (run == 0) acc_n++;
            run++;
            if (acc_n == noack_n) begin
                wb.wb_ack_i = 1'b0;
            end else if (wb.wb_adr_o == err_adr && !err_done) begin
                wb.wb_err_i = 1'b1;
                err_done = 1'b1;
            end else begin
                wb.wb_ack_i = 1'b1;
                if (wb.wb_we_o) begin
                    if (wb.wb_adr_o < 32'h20) begin
                        key_wr++;
                        key_words[wb.wb_adr_o[4:2]] = wb.wb_dat_o;
                    end else if (wb.wb_adr_o < 32'h30) begin
                        data_wr++;
                        data_words[wb.wb_adr_o[3:2]] = wb.wb_dat_o;
                    end else if (wb.wb_adr_o == 32'h40) begin
                        ctrl_wr++;
                        ctrl_val = wb.wb_dat_o;
                    end
                end else begin
                    if (wb.wb_adr_o == 32'h40) begin
                        stat_rd++;
                        wb.wb_dat_i = (stuck || stat_rd <= busy_reads) ? 32'h0001_0000 : 32'h0;
                    end else begin
                        res_rd++;
                        wb.wb_dat_i = res_mem[wb.wb_adr_o[3:2]];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit skip, input bit dec, input logic [1:0] size,
                      input logic [255:0] key, input logic [127:0] data);
        skip_key_i = skip;
        dec_i      = dec;
        size_i     = size;
        key_i      = key;
        data_i     = data;
        start_i    = 1'b1;
        @(negedge wb_clk_i);
        start_i    = 1'b0;
        key_i      = {8{32'hA5A5_5A5A}};
        data_i     = {4{32'h5A5A_A5A5}};
    endtask

    task automatic wait_end(input int limit, output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge wb_clk_i);
            if (done_o) begin got_done = 1'b1; break; end
            if (err_o)  begin got_err  = 1'b1; break; end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"},    wb.wb_cyc_o, 1'b0);
        check({tag, "_stb"},    wb.wb_stb_o, 1'b0);
        check({tag, "_we"},     wb.wb_we_o,  1'b0);
        check({tag, "_sel"},    wb.wb_sel_o, 4'h0);
        check({tag, "_adr"},    wb.wb_adr_o, 32'h0);
        check({tag, "_busy"},   busy_o,      1'b0);
        check({tag, "_done"},   done_o,      1'b0);
        check({tag, "_err"},    err_o,       1'b0);
        check({tag, "_result"}, result_o,    128'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d, e, found;

        clr_gen++;
        repeat (3) @(negedge wb_clk_i);
        check_reset_outputs("rst");
        check("rst_cti", wb.wb_cti_o, 3'b000);
        check("rst_bte", wb.wb_bte_o, 2'b00);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        // AES-128 encrypt, status busy for two reads; stray start while busy
        res_mem    = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        busy_reads = 2;
        clr_gen++;
        go(1'b0, 1'b0, 2'd0, FIPS_KEY, FIPS_PT);
        check("t1_busy_first", busy_o, 1'b1);
        check("t1_cyc_first", wb.wb_cyc_o, 1'b1);
        check("t1_adr_first", wb.wb_adr_o, 32'h0);
        check("t1_dat_first", wb.wb_dat_o, 32'h00010203);
        check("t1_sel_first", wb.wb_sel_o, 4'hF);
        check("t1_we_first", wb.wb_we_o, 1'b1);
        repeat (4) @(negedge wb_clk_i);
        go(1'b1, 1'b1, 2'd2, '1, '1);
        wait_end(200, d, e);
        check("t1_done", d, 1'b1);
        check("t1_busy_at_done", busy_o, 1'b0);
        check("t1_result", result_o, FIPS_CT);
        #1;
        check("t1_key_wr", key_wr, 8);
        check("t1_key1", key_words[1], 32'h04050607);
        check("t1_key3", key_words[3], 32'h0c0d0e0f);
        check("t1_key7", key_words[7], 32'h0);
        check("t1_data_wr", data_wr, 4);
        check("t1_data0", data_words[0], 32'h00112233);
        check("t1_data3", data_words[3], 32'hccddeeff);
        check("t1_ctrl_wr", ctrl_wr, 1);
        check("t1_ctrl", ctrl_val, 32'h0000_0001);
        check("t1_stat_rd", stat_rd, 3);
        check("t1_res_rd", res_rd, 4);
        check("t1_accesses", acc_n, 20);
        @(negedge wb_clk_i);
        check("t1_done_width", done_o, 1'b0);

        // decrypt reusing the loaded key
        res_mem    = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        busy_reads = 0;
        clr_gen++;
        go(1'b1, 1'b1, 2'd0, FIPS_KEY, FIPS_CT);
        wait_end(200, d, e);
        check("t2_done", d, 1'b1);
        check("t2_result", result_o, FIPS_PT);
        check("t2_key_wr", key_wr, 0);
        check("t2_data_wr", data_wr, 4);
        check("t2_data0", data_words[0], 32'h69c4e0d8);
        check("t2_data3", data_words[3], 32'h70b4c55a);
        check("t2_ctrl", ctrl_val, 32'h0000_0003);
        check("t2_stat_rd", stat_rd, 1);

        // start on the done cycle; third key write never acked
        noack_n = 3;
        clr_gen++;
        go(1'b0, 1'b0, 2'd0, FIPS_KEY, FIPS_PT);
        check("t3_start_on_done", busy_o, 1'b1);
        wait_end(600, d, e);
        check("t3_err_seen", e, 1'b1);
        check("t3_no_done", d, 1'b0);
        check("t3_busy", busy_o, 1'b0);
        #1;
        check("t3_stb_cycles", last_run, 255);
        check("t3_key_wr", key_wr, 2);
        check("t3_accesses", acc_n, 3);

        // status stuck busy
        @(negedge wb_clk_i);
        noack_n = -1;
        stuck   = 1'b1;
        clr_gen++;
        go(1'b1, 1'b0, 2'd1, FIPS_KEY, FIPS_PT);
        check("t4_err_cleared", err_o, 1'b0);
        wait_end(3000, d, e);
        check("t4_err_seen", e, 1'b1);
        check("t4_no_done", d, 1'b0);
        #1;
        check("t4_stat_rd", stat_rd, 1023);
        check("t4_res_rd", res_rd, 0);
        check("t4_ctrl", ctrl_val, 32'h0000_0005);
        check("t4_result_held", result_o, FIPS_PT);

        // bus error on the second data write, then a clean recovery run
        @(negedge wb_clk_i);
        stuck      = 1'b0;
        busy_reads = 1;
        err_adr    = 32'h24;
        clr_gen++;
        go(1'b0, 1'b0, 2'd0, FIPS_KEY, FIPS_PT);
        wait_end(200, d, e);
        check("t5_err_seen", e, 1'b1);
        #1;
        check("t5_key_wr", key_wr, 8);
        check("t5_data_wr", data_wr, 1);
        check("t5_ctrl_wr", ctrl_wr, 0);
        check("t5_busy", busy_o, 1'b0);
        @(negedge wb_clk_i);
        err_adr = 32'hFFFF_FFFF;
        res_mem = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
        clr_gen++;
        check("t5_err_sticky", err_o, 1'b1);
        go(1'b1, 1'b1, 2'd2, FIPS_KEY, 128'h0f0e0d0c0b0a09080706050403020100);
        check("t5_err_cleared", err_o, 1'b0);
        check("t5_busy_restart", busy_o, 1'b1);
        wait_end(200, d, e);
        check("t5_done", d, 1'b1);
        check("t5_result", result_o, 128'hdeadbeef0123456789abcdefcafef00d);
        check("t5_ctrl", ctrl_val, 32'h0000_000B);
        check("t5_data2", data_words[2], 32'h07060504);
        check("t5_stat_rd", stat_rd, 2);

        // async reset while polling
        @(negedge wb_clk_i);
        stuck = 1'b1;
        clr_gen++;
        go(1'b1, 1'b0, 2'd0, FIPS_KEY, FIPS_PT);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk_i);
            if (stat_rd >= 3 && wb.wb_cyc_o) begin found = 1'b1; break; end
        end
        check("t6_in_poll", found, 1'b1);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check("t6_idle_cyc", wb.wb_cyc_o, 1'b0);
        check("t6_idle_busy", busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
